// File: rtl/game_defs.sv
// rtl/game_defs.sv - shared move codes, grid width and move FSM encoding
package game_defs;

    localparam int COORD_W = 5;

    localparam logic [2:0] MOVE_NONE  = 3'b000;
    localparam logic [2:0] MOVE_UP    = 3'b001;
    localparam logic [2:0] MOVE_DOWN  = 3'b010;
    localparam logic [2:0] MOVE_LEFT  = 3'b011;
    localparam logic [2:0] MOVE_RIGHT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DRAW   = 2'd3
    } move_state_e;

    // Key vector is {right, left, down, up}; grant must be one-hot or zero.
    function automatic logic [2:0] encode_grant(input logic [3:0] grant);
        logic [2:0] code;
        code = MOVE_NONE;
        case (grant)
            4'b0001: code = MOVE_UP;
            4'b0010: code = MOVE_DOWN;
            4'b0100: code = MOVE_LEFT;
            4'b1000: code = MOVE_RIGHT;
            default: code = MOVE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - rate-limited key-to-move sequencer with collision commit and redraw handshake
// Optional feature: MOVE_REPEAT_EN (held key repeats every tick; otherwise edge-triggered pending flags).
module player_move_ctrl
    import game_defs::*;
#(
    parameter int                   TICK_DIV = 5000000,
    parameter logic [COORD_W-1:0]   START_X  = 5'd0,
    parameter logic [COORD_W-1:0]   START_Y  = 5'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               key_right,
    input  logic [1:0]         map,
    input  logic [COORD_W-1:0] cd_new_x,
    input  logic [COORD_W-1:0] cd_new_y,
    output logic [2:0]         cd_move,
    output logic [1:0]         cd_map,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [COORD_W-1:0] old_x,
    output logic [COORD_W-1:0] old_y,
    output logic               draw_req,
    input  logic               draw_ack,
    output logic               blocked
);

    localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    move_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         move_q, move_d;
    logic [1:0]         map_q, map_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COORD_W-1:0] old_x_q, old_x_d, old_y_q, old_y_d;
    logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;
    logic               draw_req_q, draw_req_d;
    logic               blocked_q, blocked_d;

    logic               tick;
    logic [3:0]         keys;
    logic [3:0]         req_vec;
    logic [3:0]         grant;
    logic               accept;

    assign keys  = {key_right, key_left, key_down, key_up};
    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Lowest set bit wins, which gives up > down > left > right.
    assign grant  = req_vec & ~(req_vec - 4'd1);
    assign accept = (state_q == ST_IDLE) && tick && (|req_vec);

`ifdef MOVE_REPEAT_EN
    assign req_vec = keys;
`else
    logic [3:0] key_prev_q, key_prev_d;
    logic [3:0] pend_q, pend_d;

    always_comb begin
        key_prev_d = keys;
        // A new edge on the direction being accepted re-arms it.
        pend_d     = (pend_q & ~(accept ? grant : 4'b0000)) | (keys & ~key_prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            key_prev_q <= key_prev_d;
            pend_q     <= pend_d;
        end
    end

    assign req_vec = pend_q;
`endif

    always_comb begin
        state_d    = state_q;
        move_d     = move_q;
        map_d      = map_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        draw_req_d = draw_req_q;
        blocked_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    move_d  = encode_grant(grant);
                    map_d   = map;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                nx_d    = cd_new_x;
                ny_d    = cd_new_y;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                move_d = MOVE_NONE;
                if ((nx_q == pos_x_q) && (ny_q == pos_y_q)) begin
                    blocked_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    old_x_d    = pos_x_q;
                    old_y_d    = pos_y_q;
                    pos_x_d    = nx_q;
                    pos_y_d    = ny_q;
                    draw_req_d = 1'b1;
                    state_d    = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (draw_ack) begin
                    draw_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            move_q     <= MOVE_NONE;
            map_q      <= 2'b00;
            pos_x_q    <= START_X;
            pos_y_q    <= START_Y;
            old_x_q    <= START_X;
            old_y_q    <= START_Y;
            nx_q       <= START_X;
            ny_q       <= START_Y;
            draw_req_q <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            move_q     <= move_d;
            map_q      <= map_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            draw_req_q <= draw_req_d;
            blocked_q  <= blocked_d;
        end
    end

    assign cd_move  = move_q;
    assign cd_map   = map_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign old_x    = old_x_q;
    assign old_y    = old_y_q;
    assign draw_req = draw_req_q;
    assign blocked  = blocked_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - directed bench for player_move_ctrl with a stub collision detector
module tb_player_move_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic [1:0] map = 2'd0;
    logic [4:0] cd_new_x, cd_new_y;
    logic [2:0] cd_move;
    logic [1:0] cd_map;
    logic [4:0] pos_x, pos_y, old_x, old_y;
    logic       draw_req, draw_ack = 1'b0, blocked;

    logic       blk_en = 1'b0;
    logic [4:0] blk_x = 5'd0, blk_y = 5'd0;
    logic [4:0] sx, sy;

    int n_checks = 0;
    int n_fail   = 0;
    int ex = 3, ey = 3, ox = 3, oy = 3;

    always #5 clk = ~clk;

    player_move_ctrl #(.TICK_DIV(4), .START_X(5'd3), .START_Y(5'd3)) dut (
        .clk(clk), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .map(map), .cd_new_x(cd_new_x), .cd_new_y(cd_new_y),
        .cd_move(cd_move), .cd_map(cd_map),
        .pos_x(pos_x), .pos_y(pos_y), .old_x(old_x), .old_y(old_y),
        .draw_req(draw_req), .draw_ack(draw_ack), .blocked(blocked)
    );

    // Stub detector: one cell in the move direction unless that cell is blocked.
    always_comb begin
        sx = pos_x;
        sy = pos_y;
        case (cd_move)
            3'b001:  sy = pos_y - 5'd1;
            3'b010:  sy = pos_y + 5'd1;
            3'b011:  sx = pos_x - 5'd1;
            3'b100:  sx = pos_x + 5'd1;
            default: ;
        endcase
        if (blk_en && sx == blk_x && sy == blk_y) begin
            cd_new_x = pos_x;
            cd_new_y = pos_y;
        end else begin
            cd_new_x = sx;
            cd_new_y = sy;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_keys(input logic [3:0] k);
        {key_right, key_left, key_down, key_up} = k;
    endtask

    // Waits for acceptance, checks cd_move window, and checks the T+3 outcome.
    task automatic see_move(input string tag, input logic [2:0] mv, input bit release_keys, input bit blk);
        bit found;
        for (int i = 0; i < 40 && cd_move == 3'b000; i++) step();
        found = (cd_move != 3'b000);
        chk({tag, "_accepted"}, found, 1);
        if (release_keys) set_keys(4'b0000);
        chk({tag, "_move_t1"}, cd_move, mv);
        chk({tag, "_map_t1"}, cd_map, map);
        step();
        chk({tag, "_move_t2"}, cd_move, mv);
        chk({tag, "_req_t2"}, draw_req, 0);
        step();
        chk({tag, "_move_t3"}, cd_move, 0);
        if (blk) begin
            chk({tag, "_blocked_t3"}, blocked, 1);
            chk({tag, "_pos_t3"}, {pos_x, pos_y}, {ex[4:0], ey[4:0]});
            chk({tag, "_req_t3"}, draw_req, 0);
            step();
            chk({tag, "_blocked_t4"}, blocked, 0);
            chk({tag, "_req_t4"}, draw_req, 0);
        end else begin
            ox = ex;
            oy = ey;
            case (mv)
                3'b001:  ey = ey - 1;
                3'b010:  ey = ey + 1;
                3'b011:  ex = ex - 1;
                3'b100:  ex = ex + 1;
                default: ;
            endcase
            chk({tag, "_pos_t3"}, {pos_x, pos_y}, {ex[4:0], ey[4:0]});
            chk({tag, "_old_t3"}, {old_x, old_y}, {ox[4:0], oy[4:0]});
            chk({tag, "_req_t3"}, draw_req, 1);
            chk({tag, "_blocked_t3"}, blocked, 0);
        end
    endtask

    task automatic do_ack(input string tag, input int hold);
        bit stable;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (draw_req !== 1'b1 || cd_move !== 3'b000 || pos_x !== 5'(ex) || pos_y !== 5'(ey))
                stable = 1'b0;
        end
        chk({tag, "_held"}, stable, 1);
        draw_ack = 1'b1;
        step();
        draw_ack = 1'b0;
        chk({tag, "_req_fall"}, draw_req, 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit q;
        q = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (cd_move !== 3'b000 || draw_req !== 1'b0 || blocked !== 1'b0) q = 1'b0;
        end
        chk({tag, "_quiet"}, q, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_pos", {pos_x, pos_y}, {5'd3, 5'd3});
        chk("rst_old", {old_x, old_y}, {5'd3, 5'd3});
        chk("rst_move", cd_move, 0);
        chk("rst_map", cd_map, 0);
        chk("rst_req", draw_req, 0);
        chk("rst_blocked", blocked, 0);
        reset = 1'b0;
        quiet("idle_no_key", 10);

        // Right move with ack delayed a few cycles
        map = 2'd2;
        set_keys(4'b1000);
        see_move("right", 3'b100, 1'b1, 1'b0);
        do_ack("right_ack", 3);

        // Blocked right move
        blk_en = 1'b1;
        blk_x  = 5'(ex + 1);
        blk_y  = 5'(ey);
        map    = 2'd1;
        set_keys(4'b1000);
        see_move("blk", 3'b100, 1'b1, 1'b1);
        quiet("blk_after", 6);
        blk_en = 1'b0;

        // Up and right together: up wins
        set_keys(4'b1001);
        see_move("upright", 3'b001, 1'b1, 1'b0);
        do_ack("upright_ack", 0);
`ifndef MOVE_REPEAT_EN
        // The right edge stays pending and is serviced next
        see_move("right_pend", 3'b100, 1'b0, 1'b0);
        do_ack("right_pend_ack", 0);
`endif

        // Press during DRAW with ack withheld for 10 cycles
        set_keys(4'b0010);
        see_move("down", 3'b010, 1'b1, 1'b0);
        set_keys(4'b0100);
`ifndef MOVE_REPEAT_EN
        step();
        step();
        set_keys(4'b0000);
        do_ack("down_ack", 8);
        see_move("left_retained", 3'b011, 1'b0, 1'b0);
`else
        do_ack("down_ack", 10);
        see_move("left_held", 3'b011, 1'b1, 1'b0);
`endif
        do_ack("left_ack", 0);

        // Right held over several ticks
        set_keys(4'b1000);
`ifdef MOVE_REPEAT_EN
        see_move("hold1", 3'b100, 1'b0, 1'b0);
        do_ack("hold1_ack", 0);
        see_move("hold2", 3'b100, 1'b0, 1'b0);
        do_ack("hold2_ack", 0);
        see_move("hold3", 3'b100, 1'b1, 1'b0);
        do_ack("hold3_ack", 0);
`else
        see_move("hold1", 3'b100, 1'b0, 1'b0);
        do_ack("hold1_ack", 0);
        quiet("hold_no_repeat", 16);
        set_keys(4'b0000);
`endif

        // Reset asserted while in DRAW
        set_keys(4'b0010);
        see_move("pre_rst", 3'b010, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        ex = 3;
        ey = 3;
        chk("mid_rst_pos", {pos_x, pos_y}, {5'd3, 5'd3});
        chk("mid_rst_old", {old_x, old_y}, {5'd3, 5'd3});
        chk("mid_rst_req", draw_req, 0);
        chk("mid_rst_move", cd_move, 0);
        quiet("post_rst", 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
